// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns PC, instruction register and memory-read handshake.
// Latency: start-to-valid 2 cycles; one instruction per 2 cycles with zero-wait memory and immediate ack.
// Backpressure: holds READ/address while mem_ready=0; holds ir_out/ir_valid until ir_ack.
// Optional: define FETCH_BRANCH_EN to honour branch_valid/branch_target (ports always present).
module fetch_unit #(
    parameter int                ADDR_W     = 9,
    parameter int                DATA_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s,
    input  logic              halt,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    input  logic              ir_ack,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc_out,
    output logic              w
);

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_READ = 2'b01;

`ifdef FETCH_BRANCH_EN
    localparam logic BRANCH_EN = 1'b1;
`else
    localparam logic BRANCH_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              take_branch;

    // Redirects only exist when the branch feature is built in.
    assign take_branch = BRANCH_EN & branch_valid;

    // State, PC and IR registers; reset wipes any partially completed fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_ADDR;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state logic: a branch in FETCH wins over a same-cycle mem_ready so stale data never lands in IR.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (take_branch) begin
                    pc_d = branch_target;
                end else if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ir_ack) begin
                    pc_d    = take_branch ? branch_target : pc_q + ADDR_W'(1);
                    state_d = halt ? IDLE : FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so no input-to-output combinational paths exist.
    assign mem_cmd  = (state_q == FETCH) ? CMD_READ : CMD_NONE;
    assign mem_addr = (state_q == FETCH) ? pc_q : '0;
    assign ir_out   = ir_q;
    assign ir_valid = (state_q == HOLD);
    assign pc_out   = pc_q;
    assign w        = (state_q == IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level reference model feeds an expectation queue,
// a negedge monitor pops one expected observation per cycle and compares it.
// Builds with or without FETCH_BRANCH_EN; the model follows the same macro.
module tb_fetch_unit;

    localparam int AW = 9;
    localparam int DW = 16;

`ifdef FETCH_BRANCH_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s, halt, mem_ready, ir_ack, branch_valid;
    logic [AW-1:0] branch_target;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr, pc_out;
    logic [DW-1:0] ir_out;
    logic          ir_valid, w;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_ADDR(9'h000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s             (s),
        .halt          (halt),
        .mem_cmd       (mem_cmd),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .ir_out        (ir_out),
        .ir_valid      (ir_valid),
        .ir_ack        (ir_ack),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .pc_out        (pc_out),
        .w             (w)
    );

    typedef struct packed {
        logic [1:0]    cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] ir;
        logic          irv;
        logic [AW-1:0] pc;
        logic          w;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_e, mon_a;
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: is the unit running, is an instruction waiting, PC and last loaded word.
    bit            m_run, m_have;
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_ir;

    function automatic obs_t predict();
        obs_t o;
        o.cmd  = (m_run && !m_have) ? 2'b01 : 2'b00;
        o.addr = (m_run && !m_have) ? m_pc : '0;
        o.ir   = m_ir;
        o.irv  = m_run && m_have;
        o.pc   = m_pc;
        o.w    = !m_run;
        return o;
    endfunction

    task automatic model_reset();
        m_run  = 1'b0;
        m_have = 1'b0;
        m_pc   = '0;
        m_ir   = '0;
    endtask

    // One clock of stimulus: queue the observation due at the next negedge, drive, advance the model.
    task automatic cycle(input bit i_s, input bit i_halt, input bit i_ack, input bit i_bv,
                         input logic [AW-1:0] i_tgt, input bit i_rdy, input logic [DW-1:0] i_dat);
        @(posedge clk);
        #2;
        exp_q.push_back(predict());
        s             = i_s;
        halt          = i_halt;
        ir_ack        = i_ack;
        branch_valid  = i_bv;
        branch_target = i_tgt;
        mem_ready     = i_rdy;
        mem_rdata     = i_dat;
        if (!m_run) begin
            if (i_s) begin
                m_run  = 1'b1;
                m_have = 1'b0;
            end
        end else if (!m_have) begin
            if (BR && i_bv) begin
                m_pc = i_tgt;
            end else if (i_rdy) begin
                m_have = 1'b1;
                m_ir   = i_dat;
            end
        end else if (i_ack) begin
            m_pc   = (BR && i_bv) ? i_tgt : m_pc + 9'd1;
            m_have = 1'b0;
            if (i_halt) m_run = 1'b0;
        end
    endtask

    task automatic rand_cycle();
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 3) == 0, AW'($urandom), $urandom_range(0, 2) != 0, DW'($urandom));
    endtask

    task automatic check_reset(input string name);
        obs_t a;
        a = {mem_cmd, mem_addr, ir_out, ir_valid, pc_out, w};
        vectors++;
        if (a !== {2'b00, 9'h000, 16'h0000, 1'b0, 9'h000, 1'b1}) begin
            miscompares++;
            $display("FAIL %s: got cmd=%0d addr=%h ir=%h v=%0b pc=%h w=%0b, want reset values",
                     name, a.cmd, a.addr, a.ir, a.irv, a.pc, a.w);
        end
    endtask

    // Monitor: every negedge with a pending expectation is one compared vector.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {mem_cmd, mem_addr, ir_out, ir_valid, pc_out, w};
            vectors++;
            if (mon_a !== mon_e) begin
                miscompares++;
                $display("FAIL cycle_obs @%0t: got cmd=%0d addr=%h ir=%h v=%0b pc=%h w=%0b, want cmd=%0d addr=%h ir=%h v=%0b pc=%h w=%0b",
                         $time, mon_a.cmd, mon_a.addr, mon_a.ir, mon_a.irv, mon_a.pc, mon_a.w,
                         mon_e.cmd, mon_e.addr, mon_e.ir, mon_e.irv, mon_e.pc, mon_e.w);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        s = 1'b0; halt = 1'b0; ir_ack = 1'b0; branch_valid = 1'b0;
        branch_target = '0; mem_ready = 1'b0; mem_rdata = '0;
        model_reset();
        #1;
        check_reset("reset_initial");
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Start with zero-wait memory: READ at 0, then A5A5 valid.
        cycle(1, 0, 0, 0, 9'h000, 1, 16'hA5A5);
        cycle(0, 0, 0, 0, 9'h000, 1, 16'hA5A5);
        cycle(0, 0, 0, 0, 9'h000, 0, 16'h0000);
        cycle(0, 0, 1, 0, 9'h000, 0, 16'h0000);
        // Three wait states, then load; ack with branch to 0x1F0.
        repeat (3) cycle(0, 0, 0, 0, 9'h000, 0, 16'hDEAD);
        cycle(0, 0, 0, 0, 9'h000, 1, 16'h1234);
        cycle(0, 0, 1, 1, 9'h1F0, 0, 16'h0000);
        cycle(0, 0, 0, 0, 9'h000, 1, 16'h5555);
        cycle(0, 0, 1, 0, 9'h000, 0, 16'h0000);
        // Branch in FETCH with mem_ready in the same cycle.
        cycle(0, 0, 0, 1, 9'h040, 1, 16'hBEEF);
        cycle(0, 0, 0, 0, 9'h000, 1, 16'h0F0F);
        // Halt on ack, noise while idle, then resume.
        cycle(0, 1, 1, 0, 9'h000, 0, 16'h0000);
        cycle(0, 1, 0, 1, 9'h100, 1, 16'h7777);
        cycle(0, 0, 1, 0, 9'h000, 1, 16'h8888);
        cycle(1, 0, 0, 0, 9'h000, 0, 16'h0000);
        cycle(0, 0, 0, 0, 9'h000, 0, 16'h0000);

        // Reset asserted mid-FETCH takes effect without waiting for a clock.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("reset_mid_fetch");
        model_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Run long enough at full rate for the PC to wrap from 0x1FF to 0.
        cycle(1, 0, 0, 0, 9'h000, 1, 16'h0001);
        repeat (1040) cycle(0, 0, 1, 0, 9'h000, 1, DW'($urandom));

        // Reset mid-HOLD, then randomized traffic.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("reset_mid_run");
        model_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3000) rand_cycle();

        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
